// File: rtl/n64_mem_arb_pkg.sv
// Shared types for the cartridge bus arbiter: FSM states, request fields,
// default burst limit.
package n64_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } arb_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } mem_req_t;

  localparam int DEFAULT_MAX_BURST = 64;

endpackage

// File: rtl/n64_rr_picker.sv
// Combinational round-robin search: first set req bit at or after ptr,
// wrapping around. Shared by the arbiters of the design.
module n64_rr_picker #(
  parameter  int N = 3,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    logic [W:0] c;
    valid = 1'b0;
    idx   = '0;
    c     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = {1'b0, ptr} + (W + 1)'(k);
      if (c >= (W + 1)'(N)) c = c - (W + 1)'(N);
      if (req[c[W-1:0]]) begin
        valid = 1'b1;
        idx   = c[W-1:0];
      end
    end
  end

endmodule

// File: rtl/n64_mem_arbiter.sv
// Round-robin arbiter for the shared cartridge memory bus with capped locked bursts.
// Optional N64_MEM_ARB_PI_PRIORITY_EN gives requester 0 (PI) priority and preemption.
module n64_mem_arbiter
  import n64_mem_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 3,
  parameter  int MAX_BURST = DEFAULT_MAX_BURST,
  localparam int REQ_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        write,
  input  logic [NUM_REQ-1:0][31:0]  address,
  input  logic [NUM_REQ-1:0][15:0]  wdata,
  input  logic [NUM_REQ-1:0][1:0]   wmask,
  output logic [NUM_REQ-1:0]        ack,
  output logic [15:0]               rdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      mem_request,
  output logic                      mem_write,
  output logic [31:0]               mem_address,
  output logic [15:0]               mem_wdata,
  output logic [1:0]                mem_wmask,
  input  logic                      mem_ack,
  input  logic [15:0]               mem_rdata
);

  arb_state_t         state, state_d;
  logic [REQ_W-1:0]   owner, owner_d, rr_ptr, rr_ptr_d;
  logic [REQ_W-1:0]   pick_idx, win, next_ptr;
  logic               pick_valid, pi_preempt, release_bus, mem_request_d;
  logic [7:0]         burst_cnt, burst_d;
  logic [NUM_REQ-1:0] grant_d;
  mem_req_t           cur, cur_d;
  mem_req_t           fields [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fields
    assign fields[g] = '{write: write[g], address: address[g],
                         wdata: wdata[g], wmask: wmask[g]};
  end

  n64_rr_picker #(.N(NUM_REQ)) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  function automatic logic [REQ_W-1:0] ptr_inc(input logic [REQ_W-1:0] p);
    return (p == REQ_W'(NUM_REQ - 1)) ? '0 : p + REQ_W'(1);
  endfunction

`ifdef N64_MEM_ARB_PI_PRIORITY_EN
  assign win        = req[0] ? '0 : pick_idx;
  assign pi_preempt = req[0] && (owner != '0);
  // PI releasing the bus leaves the rotation where it was.
  assign next_ptr   = (owner == '0) ? rr_ptr : ptr_inc(owner);
`else
  assign win        = pick_idx;
  assign pi_preempt = 1'b0;
  assign next_ptr   = ptr_inc(owner);
`endif

  always_comb begin
    state_d       = state;
    owner_d       = owner;
    rr_ptr_d      = rr_ptr;
    burst_d       = burst_cnt;
    grant_d       = grant;
    mem_request_d = mem_request;
    cur_d         = cur;
    release_bus   = 1'b0;
    case (state)
      IDLE: if (pick_valid) begin
        state_d       = BUSY;
        owner_d       = win;
        grant_d       = NUM_REQ'(1) << win;
        mem_request_d = 1'b1;
        cur_d         = fields[win];
        burst_d       = 8'd1;
      end
      BUSY: if (mem_ack) begin
        mem_request_d = 1'b0;
        if (lock[owner] && (burst_cnt < 8'(MAX_BURST)) && !pi_preempt) state_d = HOLD;
        else release_bus = 1'b1;
      end
      HOLD: begin
        if (pi_preempt) release_bus = 1'b1;
        else if (req[owner]) begin
          state_d       = BUSY;
          mem_request_d = 1'b1;
          cur_d         = fields[owner];
          burst_d       = burst_cnt + 8'd1;
        end else if (!lock[owner]) release_bus = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (release_bus) begin
      state_d  = IDLE;
      grant_d  = '0;
      burst_d  = '0;
      rr_ptr_d = next_ptr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      grant       <= '0;
      mem_request <= 1'b0;
      cur         <= '0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      rr_ptr      <= rr_ptr_d;
      burst_cnt   <= burst_d;
      grant       <= grant_d;
      mem_request <= mem_request_d;
      cur         <= cur_d;
    end
  end

  // grant is one-hot while BUSY, so masking it routes the ack to the owner.
  assign ack         = (state == BUSY && mem_ack) ? grant : '0;
  assign rdata       = mem_rdata;
  assign mem_write   = cur.write;
  assign mem_address = cur.address;
  assign mem_wdata   = cur.wdata;
  assign mem_wmask   = cur.wmask;

endmodule

// File: tb/tb_n64_mem_arbiter.sv
// Scoreboard bench for n64_mem_arbiter: per-requester beat queues drive the DUT,
// a transaction-level round-robin model predicts the served beat order.
module tb_n64_mem_arbiter;
  localparam int NUM_REQ   = 3;
  localparam int MAX_BURST = 4;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } beat_t;
  typedef struct {
    int    idx;
    beat_t b;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NUM_REQ-1:0]       req, lock, write, ack, grant;
  logic [NUM_REQ-1:0][31:0] address;
  logic [NUM_REQ-1:0][15:0] wdata;
  logic [NUM_REQ-1:0][1:0]  wmask;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [31:0] mem_address;
  logic [1:0]  mem_wmask;
  logic        mem_request, mem_write, mem_ack;

  n64_mem_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .write(write),
    .address(address), .wdata(wdata), .wmask(wmask), .ack(ack), .rdata(rdata),
    .grant(grant), .mem_request(mem_request), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  beat_t aq [NUM_REQ][$];   // what each requester still wants to transfer
  beat_t mq [NUM_REQ][$];   // model's working copy
  exp_t  exp_q [$];
  int    n_cmp = 0, n_bad = 0, model_ptr = 0, wait_cnt = 0;
  bit    hold_ack = 1'b0, use_pat = 1'b0;
  logic [15:0] rd_pat = 16'hBEEF;
  logic [NUM_REQ-1:0] ack_snap = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic int agent_pending();
    int n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += aq[i].size();
    return n;
  endfunction

  function automatic int model_pending();
    int n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += mq[i].size();
    return n;
  endfunction

  task automatic add_beat(input int i, input logic w, input logic [31:0] a,
                          input logic [15:0] d, input logic [1:0] m);
    beat_t b;
    b.write = w; b.addr = a; b.wdata = d; b.wmask = m;
    aq[i].push_back(b);
  endtask

  task automatic add_req(input int i, input int n);
    for (int k = 0; k < n; k++)
      add_beat(i, 1'($urandom), $urandom, 16'($urandom), 2'($urandom));
  endtask

  // Service order: pick the first pending requester from the pointer, serve up to
  // MAX_BURST of its beats, move the pointer past it; leftovers queue up again.
  task automatic model_round();
    int w, c;
    exp_t e;
    for (int i = 0; i < NUM_REQ; i++) mq[i] = aq[i];
    while (model_pending() > 0) begin
      w = -1;
`ifdef N64_MEM_ARB_PI_PRIORITY_EN
      if (mq[0].size() > 0) w = 0;
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (model_ptr + k) % NUM_REQ;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      for (int n = 0; n < MAX_BURST && mq[w].size() > 0; n++) begin
        e.idx = w;
        e.b   = mq[w].pop_front();
        exp_q.push_back(e);
      end
`ifdef N64_MEM_ARB_PI_PRIORITY_EN
      if (w != 0) model_ptr = (w + 1) % NUM_REQ;
`else
      model_ptr = (w + 1) % NUM_REQ;
`endif
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]  = aq[i].size() > 0;
      lock[i] = aq[i].size() > 1;
      if (aq[i].size() > 0) begin
        write[i]   = aq[i][0].write;
        address[i] = aq[i][0].addr;
        wdata[i]   = aq[i][0].wdata;
        wmask[i]   = aq[i][0].wmask;
      end
    end
  endtask

  // One clock: requesters retire acked beats, then the memory model responds.
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (ack_snap[i] && aq[i].size() > 0) void'(aq[i].pop_front());
    drive();
    if (hold_ack) mem_ack = 1'b0;
    else if (mem_request) begin
      if (wait_cnt == 0) begin
        mem_ack  = 1'b1;
        wait_cnt = $urandom_range(0, 3);
      end else begin
        mem_ack = 1'b0;
        wait_cnt--;
      end
    end else mem_ack = ($urandom_range(0, 7) == 0);
    mem_rdata = use_pat ? rd_pat : 16'($urandom);
    @(negedge clk); #1;
    ack_snap = ack;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      step();
      done = (exp_q.size() == 0) && (agent_pending() == 0);
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL round_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
      for (int i = 0; i < NUM_REQ; i++) aq[i].delete();
    end
    step();
  endtask

  task automatic run_round();
    model_round();
    wait_done();
  endtask

  // Monitor
  exp_t               mon_e;
  logic [NUM_REQ-1:0] onehot;
  logic               p_busy = 1'b0, p_idle_req = 1'b0;
  logic [50:0]        p_fields = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      p_busy     = 1'b0;
      p_idle_req = 1'b0;
    end else begin
      chk("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
      if (p_idle_req) chk("req_to_mem_request", {grant != '0, mem_request}, 2'b11);
      if (p_busy)
        chk("busy_stable", {mem_request, mem_write, mem_address, mem_wdata, mem_wmask},
            {1'b1, p_fields});
      if (mem_request && mem_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got beat to %0h, expected none", mem_address);
        end else begin
          mon_e  = exp_q.pop_front();
          onehot = '0;
          onehot[mon_e.idx] = 1'b1;
          chk("beat_grant", grant, onehot);
          chk("beat_ack", ack, onehot);
          chk("beat_write", mem_write, mon_e.b.write);
          chk("beat_addr", mem_address, mon_e.b.addr);
          chk("beat_wdata", mem_wdata, mon_e.b.wdata);
          chk("beat_wmask", mem_wmask, mon_e.b.wmask);
          chk("beat_rdata", rdata, mem_rdata);
        end
      end else chk("ack_idle", ack, '0);
      p_idle_req = (grant == '0) && (req != '0);
      p_busy     = mem_request && !mem_ack;
      p_fields   = {mem_write, mem_address, mem_wdata, mem_wmask};
    end
  end

  bit injected;

  initial begin
    req = '0; lock = '0; write = '0; address = '0; wdata = '0; wmask = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, '0);
    chk("rst_mem_request", mem_request, 0);
    chk("rst_mem_fields", {mem_write, mem_address, mem_wdata, mem_wmask}, '0);
    chk("rst_ack", ack, '0);
    @(negedge clk); #2 reset_n = 1'b1;

    // contention from reset: one beat each
    for (int i = 0; i < NUM_REQ; i++) add_req(i, 1);
    run_round();

    // single read with fixed data
    use_pat = 1'b1;
    add_beat(1, 1'b0, 32'h0010_0000, 16'h0, 2'b11);
    run_round();
    use_pat = 1'b0;

    // locked 4-beat write burst from requester 2, PI request arriving mid-burst
    for (int k = 1; k <= 4; k++) add_beat(2, 1'b1, $urandom, 16'(k), 2'b11);
    model_round();
    step(); step();
    injected = 1'b0;
    for (int t = 0; t < 400 && exp_q.size() > 0 && exp_q[0].idx == 2; t++) begin
      chk("burst_grant", grant, 3'b100);
`ifndef N64_MEM_ARB_PI_PRIORITY_EN
      if (!injected && exp_q.size() <= 2) begin
        add_req(0, 1);
        exp_q.push_back('{0, aq[0][0]});
        model_ptr = 1;
        injected  = 1'b1;
      end
`endif
      step();
    end
    wait_done();

    // simultaneous 0 and 1
    add_req(0, 1); add_req(1, 1);
    run_round();

    // burst cap with PI pending
    add_req(1, 6); add_req(0, 1);
    run_round();

    // reset while a transfer is outstanding
    hold_ack = 1'b1;
    add_req(1, 1);
    model_round();
    for (int t = 0; t < 10 && !mem_request; t++) step();
    chk("busy_before_reset", mem_request, 1);
    @(posedge clk); #3 reset_n = 1'b0; #1;
    chk("abort_mem_request", mem_request, 0);
    chk("abort_grant", grant, '0);
    chk("abort_ack", ack, '0);
    for (int i = 0; i < NUM_REQ; i++) aq[i].delete();
    exp_q.delete();
    drive();
    hold_ack = 1'b0; mem_ack = 1'b0; ack_snap = '0; model_ptr = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    add_req(1, 1); add_req(2, 2);
    run_round();

    // random rounds
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 1) == 1) add_req(i, $urandom_range(1, 6));
      if (agent_pending() == 0) add_req($urandom_range(0, NUM_REQ - 1), 1);
      run_round();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
